counter_modulo: RTL
===================

COUNTER_MODULO -- requirements
Module: counter_modulo

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter MODULO, default 10, count range 0..MODULO-1; legal 2..2**WIDTH.
REQ-003 SHALL have parameter MODE, default CNT_WRAP, of type counter_mode_t (CNT_WRAP, CNT_SATURATE).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ena  input  1  count enable.
REQ-007 SHALL have port dir  input  1  direction: 0 up, 1 down.
REQ-008 SHALL have port ld  input  1  synchronous load request.
REQ-009 SHALL have port dat  input  WIDTH  load value.
REQ-010 SHALL have port cnt  output  WIDTH  counter value, registered.
REQ-011 SHALL have port tc  output  1  terminal count, combinational from cnt and dir.
REQ-012 SHALL have port wrp  output  1  wrap/limit event pulse, registered.
REQ-013 SHALL have port ovf  output  1  sticky overflow/underflow flag, registered.

Function
REQ-014 Update priority SHALL be rst > ld > ena; when none is asserted, all registers hold and wrp is 0.
REQ-015 ld SHALL set cnt to dat next cycle; dat >= MODULO SHALL load MODULO-1 (clamp).
REQ-016 ld SHALL clear ovf and drive wrp 0 next cycle, regardless of ena or dir.
REQ-017 ena with dir=0 and cnt < MODULO-1 SHALL increment cnt by 1 next cycle.
REQ-018 ena with dir=1 and cnt > 0 SHALL decrement cnt by 1 next cycle.
REQ-019 tc SHALL be 1 when (dir=0 and cnt==MODULO-1) or (dir=1 and cnt==0), else 0.
REQ-020 ena with tc=1 in CNT_WRAP SHALL set cnt to 0 (up) or MODULO-1 (down) next cycle.
REQ-021 ena with tc=1 in CNT_SATURATE SHALL hold cnt.
REQ-022 ena with tc=1 SHALL, in either mode, set wrp to 1 for exactly the next cycle (aligned with the new/held cnt) and set ovf to 1.
REQ-023 wrp SHALL be 0 in every cycle not directly following a REQ-022 event; consecutive terminal steps SHALL give consecutive wrp pulses.
REQ-024 dir change SHALL take effect in the same cycle (tc and step direction use current dir).
REQ-025 MODULO == 2**WIDTH SHALL behave as a plain binary wrap counter with no extra-width overflow in compares.
REQ-026 Arithmetic SHALL be done in WIDTH bits; cnt SHALL never leave 0..MODULO-1 after reset.
REQ-027 Illegal MODULO (<2 or >2**WIDTH) SHALL be rejected at elaboration with a fatal message.

Reset
REQ-028 rst SHALL set cnt=0, wrp=0, ovf=0 next rising edge, overriding ld and ena.
REQ-029 rst asserted mid-count SHALL discard any in-progress wrap event (no wrp pulse after reset).
REQ-030 First ena after rst release SHALL be acted on in that same cycle.

Structure
REQ-031 counter_mode_t SHALL be defined in the shared package counter_pkg, imported by RTL and bench.
REQ-032 No sub-module SHALL be used; next-value and tc logic SHALL be local to counter_modulo.
REQ-033 Bench SHALL instantiate both modes side by side against one behavioural reference model.

Verification (WIDTH=4, MODULO=10 unless stated)
REQ-034 Up wrap: rst, then ena=1 dir=0 for 11 cycles -> cnt 1..9,0,1; wrp=1 only with cnt=0; ovf=1 from then.
REQ-035 Down wrap/saturate: ld dat=1, then ena=1 dir=1 x3 -> WRAP cnt 0,9,8; SATURATE cnt 0,0,0 with wrp 0,1,1.
REQ-036 Load clamp and priority: ld=1 dat=13 ena=1 -> cnt=9, ovf=0, wrp=0; ld=1 with rst=1 -> cnt=0.
REQ-037 Reset mid-operation: cnt=9, ena=1 dir=0 with rst=1 same cycle -> cnt=0, wrp=0, ovf=0.
REQ-038 Full binary range: MODULO=16, 18 enabled up steps -> cnt 1..15,0,1,2; single wrp at cnt=0.
REQ-039 Random ena/dir/ld for 1000 cycles in both modes -> cnt, tc, wrp, ovf match reference every cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter and its bench.
//   counter_mode_t : behaviour at the terminal count (wrap around or saturate).
package counter_pkg;

  typedef enum logic [0:0] {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } counter_mode_t;

endpackage

// File: rtl/counter_modulo.sv
// Up/down modulo-N counter with synchronous load, terminal-count detect,
// a one-cycle wrap/limit pulse and a sticky overflow/underflow flag.
//
// Parameters
//   WIDTH  : counter width in bits
//   MODULO : count range 0..MODULO-1, legal 2..2**WIDTH
//   MODE   : CNT_WRAP wraps at the terminal count, CNT_SATURATE holds there
// Ports
//   clk : clock, all state changes on its rising edge
//   rst : synchronous active-high reset (cnt, wrp, ovf -> 0)
//   ena : count enable
//   dir : 0 counts up, 1 counts down
//   ld  : synchronous load of dat (clamped to MODULO-1), beats ena
//   dat : load value
//   cnt : registered count
//   tc  : terminal count for the current dir, combinational
//   wrp : registered one-cycle pulse after an enabled step at terminal count
//   ovf : registered sticky flag, set by a terminal step, cleared by ld/rst
module counter_modulo
  import counter_pkg::*;
#(
  parameter int unsigned   WIDTH  = 4,
  parameter int unsigned   MODULO = 10,
  parameter counter_mode_t MODE   = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] dat,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrp,
  output logic             ovf
);

  // Range check done in 64 bits so MODULO == 2**WIDTH is representable.
  if ((MODULO < 2) || (64'(MODULO) > (64'd1 << WIDTH))) begin : g_bad_modulo
    $fatal(1, "counter_modulo: MODULO=%0d illegal for WIDTH=%0d", MODULO, WIDTH);
  end

  // All compares and arithmetic stay in WIDTH bits; MaxVal always fits.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] cnt_d;
  logic             wrp_d;
  logic             ovf_d;

  assign tc = dir ? (cnt == '0) : (cnt == MaxVal);

  always_comb begin
    cnt_d = cnt;
    wrp_d = 1'b0;
    ovf_d = ovf;
    if (ld) begin
      cnt_d = (dat > MaxVal) ? MaxVal : dat;
      ovf_d = 1'b0;
    end else if (ena) begin
      if (tc) begin
        wrp_d = 1'b1;
        ovf_d = 1'b1;
        if (MODE == CNT_WRAP) begin
          cnt_d = dir ? MaxVal : '0;
        end
      end else begin
        cnt_d = dir ? (cnt - One) : (cnt + One);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wrp <= 1'b0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_d;
      wrp <= wrp_d;
      ovf <= ovf_d;
    end
  end

endmodule
